// File: rtl/pixel_scanner.sv
// pixel_scanner
//   Walks a SCREEN_WIDTH x SCREEN_HEIGHT frame in raster order, presenting one
//   pixel coordinate at a time to the mapping stage. A pixel is consumed in a
//   cycle where en is high and neither downstream stall input is asserted.
//
// Ports
//   clk               : sole clock, rising edge
//   reset             : synchronous, active-high
//   start             : begin a new frame scan (honoured only in IDLE)
//   restart           : abort and rescan from (0,0), honoured in any state
//   full_queue        : downstream queue full, stalls the scan
//   distributor_ready : downstream distributor busy, stalls the scan
//   en                : pixel_x/pixel_y valid for the mapping stage
//   pixel_x, pixel_y  : current coordinate
//   busy              : high while scanning (same as en)
//   frame_done        : one-cycle pulse after the last pixel is accepted
//   frame_count       : completed frames, modulo 256
module pixel_scanner #(
    parameter int PIXEL_DATA_WIDTH = 10,
    parameter int SCREEN_WIDTH     = 640,
    parameter int SCREEN_HEIGHT    = 480
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        restart,
    input  logic                        full_queue,
    input  logic                        distributor_ready,
    output logic                        en,
    output logic [PIXEL_DATA_WIDTH-1:0] pixel_x,
    output logic [PIXEL_DATA_WIDTH-1:0] pixel_y,
    output logic                        busy,
    output logic                        frame_done,
    output logic [7:0]                  frame_count
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST = PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST = PIXEL_DATA_WIDTH'(SCREEN_HEIGHT - 1);

    state_t state;
    state_t next_state;

    logic                        accept;
    logic                        last_x;
    logic                        last_y;
    logic [PIXEL_DATA_WIDTH-1:0] x_next;
    logic [PIXEL_DATA_WIDTH-1:0] y_next;
    logic                        frame_done_next;
    logic [7:0]                  frame_count_next;

    assign accept = en && !full_queue && !distributor_ready;
    assign last_x = (pixel_x == X_LAST);
    assign last_y = (pixel_y == Y_LAST);

    // State register plus registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            en          <= 1'b0;
            busy        <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= next_state;
            en          <= (next_state == SCAN);
            busy        <= (next_state == SCAN);
            pixel_x     <= x_next;
            pixel_y     <= y_next;
            frame_done  <= frame_done_next;
            frame_count <= frame_count_next;
        end
    end

    // Next-state logic; restart overrides everything, including the final accept
    always_comb begin
        next_state = state;
        if (restart) begin
            next_state = SCAN;
        end else begin
            case (state)
                IDLE:    if (start) next_state = SCAN;
                SCAN:    if (accept && last_x && last_y) next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Next values for the coordinate counters and frame bookkeeping
    always_comb begin
        x_next           = pixel_x;
        y_next           = pixel_y;
        frame_done_next  = 1'b0;
        frame_count_next = frame_count;
        if (restart) begin
            x_next = '0;
            y_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_next = '0;
                        y_next = '0;
                    end
                end
                SCAN: begin
                    if (accept) begin
                        if (!last_x) begin
                            x_next = pixel_x + 1'b1;
                        end else if (!last_y) begin
                            x_next = '0;
                            y_next = pixel_y + 1'b1;
                        end else begin
                            // Coordinates hold the last pixel through DONE
                            frame_done_next  = 1'b1;
                            frame_count_next = frame_count + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/pixel_scanner.md
PIXEL_SCANNER -- requirements
Module: pixel_scanner

Interface
REQ-001 SHALL have parameter PIXEL_DATA_WIDTH, default 10, width of pixel coordinate outputs.
REQ-002 SHALL have parameter SCREEN_WIDTH, default 640, number of columns per frame.
REQ-003 SHALL have parameter SCREEN_HEIGHT, default 480, number of rows per frame.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request a new frame scan; acted on only in IDLE.
REQ-007 SHALL have port restart  input  1  abort the current scan and begin again from pixel (0,0); acted on in any state.
REQ-008 SHALL have port full_queue  input  1  downstream queue full; stalls the scan.
REQ-009 SHALL have port distributor_ready  input  1  downstream distributor busy; stalls the scan.
REQ-010 SHALL have port en  output  1  current pixel_x/pixel_y are valid for the mapping stage.
REQ-011 SHALL have port pixel_x  output  PIXEL_DATA_WIDTH  current column, 0..SCREEN_WIDTH-1.
REQ-012 SHALL have port pixel_y  output  PIXEL_DATA_WIDTH  current row, 0..SCREEN_HEIGHT-1.
REQ-013 SHALL have port busy  output  1  high while in SCAN.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.
REQ-015 SHALL have port frame_count  output  8  number of completed frames, modulo 256.

Function
REQ-016 SHALL implement states IDLE, SCAN, DONE; all outputs registered.
REQ-017 A pixel SHALL be accepted in a cycle when en && !full_queue && !distributor_ready; this is the mapping stage's capture condition.
REQ-018 In IDLE with start=1, restart=0: next cycle state=SCAN, pixel_x=0, pixel_y=0, en=1.
REQ-019 en SHALL be 1 exactly when state=SCAN; busy SHALL equal en.
REQ-020 In SCAN with no acceptance, pixel_x, pixel_y and state SHALL hold; no timeout.
REQ-021 On acceptance with pixel_x<SCREEN_WIDTH-1: next pixel_x=pixel_x+1, pixel_y unchanged.
REQ-022 On acceptance with pixel_x=SCREEN_WIDTH-1 and pixel_y<SCREEN_HEIGHT-1: next pixel_x=0, pixel_y=pixel_y+1.
REQ-023 On acceptance of (SCREEN_WIDTH-1, SCREEN_HEIGHT-1): next state=DONE, en=0, frame_done=1, frame_count incremented by 1, wrapping 255->0; pixel_x/pixel_y hold the last pixel.
REQ-024 DONE SHALL last exactly one cycle, then IDLE with frame_done=0.
REQ-025 start SHALL be ignored in SCAN and DONE.
REQ-026 restart=1 in any state: next cycle state=SCAN, pixel_x=0, pixel_y=0, en=1, frame_done=0, frame_count unchanged.
REQ-027 restart SHALL take priority over start and over acceptance, including acceptance of the last pixel; that frame SHALL not be counted and frame_done SHALL not pulse.
REQ-028 One scan cycle SHALL accept at most one pixel; with no stalls a frame SHALL take SCREEN_WIDTH*SCREEN_HEIGHT cycles in SCAN plus 1 cycle in DONE.
REQ-029 Coordinate counters SHALL never exceed SCREEN_WIDTH-1 / SCREEN_HEIGHT-1; both parameters SHALL fit in PIXEL_DATA_WIDTH bits.

Reset
REQ-030 reset=1 SHALL force state=IDLE, en=0, busy=0, pixel_x=0, pixel_y=0, frame_done=0, frame_count=0 at the next edge.
REQ-031 reset SHALL take priority over start, restart and acceptance, including mid-scan; no frame_done pulse SHALL result.
REQ-032 After reset is released, the block SHALL stay in IDLE until start or restart.

Verification (SCREEN_WIDTH=4, SCREEN_HEIGHT=3)
REQ-033 Reset, then start pulse, with full_queue=0 and distributor_ready=0 -> en high for 12 cycles with (x,y) sequence (0,0),(1,0),(2,0),(3,0),(0,1)..(3,2); frame_done=1 for one cycle after (3,2); frame_count=1; then IDLE.
REQ-034 Mid-frame at (2,1), hold full_queue=1 for 5 cycles, then distributor_ready=1 for 3 cycles -> (2,1) held for 8 cycles; next pixel (3,1); no skipped or duplicated pixels.
REQ-035 Assert restart at (1,2) -> next cycle (0,0), en=1, frame_count unchanged; the full 12-pixel frame follows.
REQ-036 restart in the same cycle the last pixel (3,2) is accepted -> no frame_done pulse; frame_count unchanged; scan resumes at (0,0).
REQ-037 Assert reset at (3,0) with start=1 -> next cycle IDLE, en=0, (0,0), frame_count=0; start after release begins a fresh frame.
REQ-038 Run 256 back-to-back frames, pulsing start in IDLE -> frame_count wraps 255->0; start during SCAN and DONE has no effect.
